// File: rtl/jesd204b_tx_link.sv
// JESD204B transmit link-layer sequencer for one lane: CGS (K28.5) until SYNC~
// releases, then an LMFC-aligned ILAS, then user data; sustained SYNC~ falls back to CGS.
module jesd204b_tx_link #(
  parameter int PARALLEL_OCTETS  = 4,
  parameter int F                = 2,
  parameter int K                = 16,
  parameter int ILAS_MULTIFRAMES = 4,
  parameter int RESYNC_BEATS     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sync_ni,
  input  logic [111:0]                   ilas_cfg_i,
  input  logic [8*PARALLEL_OCTETS-1:0]   tx_data_i,
  output logic                           tx_ready_o,
  output logic [8*PARALLEL_OCTETS-1:0]   tx_octets_o,
  output logic [PARALLEL_OCTETS-1:0]     tx_charisk_o,
  output logic                           lmfc_o,
  output logic                           link_up_o
);

  localparam int P   = PARALLEL_OCTETS;
  localparam int MF  = F * K;
  localparam int BPM = MF / P;
  localparam int LW  = (BPM > 1) ? $clog2(BPM) : 1;
  localparam int MW  = $clog2(ILAS_MULTIFRAMES);

  typedef enum logic [1:0] {ST_CGS, ST_ILAS, ST_DATA} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lmfc_cnt_q;
  logic [MW-1:0]   mf_cnt_q;
  logic [3:0]      low_cnt_q;
  logic            lmfc_wrap;
  logic            resync;
  logic [8*P-1:0]  octets_d;
  logic [P-1:0]    charisk_d;

  assign lmfc_wrap  = (lmfc_cnt_q == LW'(BPM - 1));
  // Resync fires on the RESYNC_BEATS-th consecutive low beat outside CGS.
  assign resync     = (state_q != ST_CGS) && !sync_ni && (low_cnt_q == 4'(RESYNC_BEATS - 1));
  assign tx_ready_o = (state_q == ST_DATA);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CGS:  if (sync_ni && lmfc_wrap) state_d = ST_ILAS;
      ST_ILAS: begin
        if (resync) state_d = ST_CGS;
        else if (mf_cnt_q == MW'(ILAS_MULTIFRAMES - 1) && lmfc_wrap) state_d = ST_DATA;
      end
      ST_DATA: if (resync) state_d = ST_CGS;
      default: state_d = ST_CGS;
    endcase
  end

  always_comb begin
    octets_d  = '0;
    charisk_d = '0;
    for (int lane = 0; lane < P; lane++) begin
      int idx;
      idx = int'(lmfc_cnt_q) * P + lane;
      case (state_q)
        ST_DATA: begin
          octets_d[8*lane +: 8] = tx_data_i[8*lane +: 8];
          charisk_d[lane]       = 1'b0;
        end
        ST_ILAS: begin
          if (idx == 0) begin
            octets_d[8*lane +: 8] = 8'h1C;
            charisk_d[lane]       = 1'b1;
          end else if (idx == MF - 1) begin
            octets_d[8*lane +: 8] = 8'h7C;
            charisk_d[lane]       = 1'b1;
          end else if (mf_cnt_q == MW'(1) && idx == 1) begin
            octets_d[8*lane +: 8] = 8'h9C;
            charisk_d[lane]       = 1'b1;
          end else if (mf_cnt_q == MW'(1) && idx >= 2 && idx <= 15) begin
            octets_d[8*lane +: 8] = ilas_cfg_i[8*(idx-2) +: 8];
            charisk_d[lane]       = 1'b0;
          end else begin
            octets_d[8*lane +: 8] = 8'(idx);
            charisk_d[lane]       = 1'b0;
          end
        end
        default: begin
          octets_d[8*lane +: 8] = 8'hBC;
          charisk_d[lane]       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_CGS;
      lmfc_cnt_q   <= '0;
      mf_cnt_q     <= '0;
      low_cnt_q    <= '0;
      tx_octets_o  <= {P{8'hBC}};
      tx_charisk_o <= '1;
      lmfc_o       <= 1'b0;
      link_up_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lmfc_cnt_q <= lmfc_wrap ? '0 : lmfc_cnt_q + LW'(1);

      // Zero everywhere outside ILAS, so entering ILAS always starts at multiframe 0.
      if (state_q != ST_ILAS)  mf_cnt_q <= '0;
      else if (lmfc_wrap)      mf_cnt_q <= mf_cnt_q + MW'(1);

      if (state_q == ST_CGS || sync_ni) low_cnt_q <= '0;
      else if (low_cnt_q != 4'hF)       low_cnt_q <= low_cnt_q + 4'd1;

      tx_octets_o  <= octets_d;
      tx_charisk_o <= charisk_d;
      lmfc_o       <= (lmfc_cnt_q == '0);
      link_up_o    <= (state_q == ST_DATA);
    end
  end

endmodule

// File: tb/tb_jesd204b_tx_link.sv
// Directed bench for jesd204b_tx_link with P=4, F=2, K=16 (BPM=8): CGS, ILAS
// contents, data pass-through, resync fallback and mid-ILAS reset.
module tb_jesd204b_tx_link;

  logic         clk = 1'b0;
  logic         rst;
  logic         sync_n;
  logic [111:0] ilas_cfg;
  logic [31:0]  tx_data;
  logic         tx_ready;
  logic [31:0]  tx_octets;
  logic [3:0]   tx_charisk;
  logic         lmfc;
  logic         link_up;

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  int   cnt     = 0;
  logic exp_lmfc;

  logic [31:0] ramp_oct [8] = '{32'h0302011C, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                                32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h7C1E1D1C};
  logic [3:0]  ramp_k   [8] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
  logic [31:0] cfg_oct  [8] = '{32'h01009C1C, 32'h05040302, 32'h09080706, 32'h0D0C0B0A,
                                32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h7C1E1D1C};
  logic [3:0]  cfg_k    [8] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};

  jesd204b_tx_link #(
    .PARALLEL_OCTETS(4), .F(2), .K(16), .ILAS_MULTIFRAMES(4), .RESYNC_BEATS(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sync_ni     (sync_n),
    .ilas_cfg_i  (ilas_cfg),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .tx_octets_o (tx_octets),
    .tx_charisk_o(tx_charisk),
    .lmfc_o      (lmfc),
    .link_up_o   (link_up)
  );

  always #5 clk = ~clk;

  // Advance one beat; the bench tracks the free-running LMFC count itself.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_lmfc = 1'b0;
      cnt      = 0;
    end else begin
      exp_lmfc = (cnt == 0);
      cnt      = (cnt + 1) % 8;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cgs(input string tag);
    check({tag, "_oct"}, tx_octets, 32'hBCBCBCBC);
    check({tag, "_k"}, 32'(tx_charisk), 32'hF);
    check({tag, "_link"}, 32'(link_up), 32'h0);
  endtask

  initial begin
    int guard;
    rst      = 1'b1;
    sync_n   = 1'b0;
    tx_data  = 32'h0;
    ilas_cfg = 112'h0D0C0B0A09080706050403020100;

    step();
    check_cgs("reset");
    check("reset_lmfc", 32'(lmfc), 32'h0);
    check("reset_ready", 32'(tx_ready), 32'h0);
    rst = 1'b0;

    // CGS with SYNC~ asserted; one high glitch away from the LMFC wrap is ignored.
    for (int k = 0; k < 19; k++) begin
      sync_n = (k == 10);
      step();
      check_cgs("cgs");
      check("cgs_lmfc", 32'(lmfc), 32'(exp_lmfc));
      check("cgs_ready", 32'(tx_ready), 32'h0);
    end

    // SYNC~ releases at lmfc count 3; CGS continues up to the wrap.
    sync_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_cgs("cgs_wait");
    end

    for (int mf = 0; mf < 4; mf++) begin
      for (int b = 0; b < 8; b++) begin
        step();
        check("ilas_oct", tx_octets, (mf == 1) ? cfg_oct[b] : ramp_oct[b]);
        check("ilas_k", 32'(tx_charisk), 32'((mf == 1) ? cfg_k[b] : ramp_k[b]));
        check("ilas_lmfc", 32'(lmfc), 32'(b == 0));
        check("ilas_link", 32'(link_up), 32'h0);
        check("ilas_ready", 32'(tx_ready), 32'(mf == 3 && b == 7));
      end
    end

    tx_data = 32'hDEADBEEF;
    step();
    check("data_oct", tx_octets, 32'hDEADBEEF);
    check("data_k", 32'(tx_charisk), 32'h0);
    check("data_link", 32'(link_up), 32'h1);
    check("data_ready", 32'(tx_ready), 32'h1);

    // Three low beats then high: link stays up.
    sync_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tx_data = 32'h01020300 + 32'(k);
      step();
      check("short_low_oct", tx_octets, 32'h01020300 + 32'(k));
      check("short_low_link", 32'(link_up), 32'h1);
      check("short_low_ready", 32'(tx_ready), 32'h1);
    end
    sync_n  = 1'b1;
    tx_data = 32'hA5A5A5A5;
    step();
    check("short_low_end_oct", tx_octets, 32'hA5A5A5A5);
    check("short_low_end_ready", 32'(tx_ready), 32'h1);

    // Four low beats: the 4th beat's data still goes out, then CGS.
    sync_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx_data = 32'h11111111 * 32'(k + 1);
      step();
      check("resync_oct", tx_octets, 32'h11111111 * 32'(k + 1));
      check("resync_link", 32'(link_up), 32'h1);
      check("resync_ready", 32'(tx_ready), 32'(k != 3));
    end
    step();
    check_cgs("resync_cgs");

    // Re-enter ILAS, then reset part-way through mf2.
    sync_n = 1'b1;
    guard  = 0;
    do begin
      step();
      guard++;
    end while (cnt != 0 && guard < 9);
    step();
    check("reilas_oct", tx_octets, 32'h0302011C);
    check("reilas_k", 32'(tx_charisk), 32'h1);
    for (int k = 0; k < 17; k++) step();
    check("pre_rst_oct", tx_octets, 32'h07060504);

    rst = 1'b1;
    step();
    check_cgs("mid_rst");
    check("mid_rst_lmfc", 32'(lmfc), 32'h0);
    check("mid_rst_ready", 32'(tx_ready), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      step();
      check_cgs("post_rst_cgs");
    end
    step();
    check("restart_oct0", tx_octets, 32'h0302011C);
    check("restart_k0", 32'(tx_charisk), 32'h1);
    check("restart_lmfc", 32'(lmfc), 32'h1);
    step();
    check("restart_oct1", tx_octets, 32'h07060504);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jesd204b_tx_link.md
Name: jesd204b_tx_link

Overview:
- Transmit-side JESD204B link-layer sequencer; the peer of the RX code-group-sync / lane-alignment logic.
- Drives one lane's parallel octet stream into the 8b/10b encoder.
- While SYNC~ is asserted it emits K28.5 (CGS). After SYNC~ deasserts it emits the 4-multiframe Initial Lane Alignment Sequence (ILAS) starting on an LMFC boundary, then passes user data.
- Falls back to CGS on a sustained SYNC~ re-request.

Parameters:
- PARALLEL_OCTETS, 4: octets per beat (P). Octet 0 is bits [7:0] and is first in time.
- F, 2: octets per frame.
- K, 16: frames per multiframe. F*K must be a multiple of P and at least 17.
- ILAS_MULTIFRAMES, 4: number of ILAS multiframes. Must be at least 2.
- RESYNC_BEATS, 4: consecutive beats with sync_ni low, in ILAS/DATA, that force a return to CGS. Range 1..15.

Ports:
- clk_i, in, 1: beat clock.
- rst_i, in, 1: synchronous reset, active-high.
- sync_ni, in, 1: SYNC~ from the receiver, active-low, already synchronous to clk_i.
- ilas_cfg_i, in, 112: 14 ILAS link-config octets; octet n is [8n+7:8n]. Must be static outside CGS.
- tx_data_i, in, 8*P: user data octets.
- tx_ready_o, out, 1: tx_data_i is consumed this cycle.
- tx_octets_o, out, 8*P: octets to the encoder.
- tx_charisk_o, out, P: per-octet K-character flag.
- lmfc_o, out, 1: high when tx_octets_o carries beat 0 of a multiframe.
- link_up_o, out, 1: high when tx_octets_o carries user data.

Behaviour:
- Derived constants: MF = F*K octets per multiframe; BPM = MF/P beats per multiframe.
- lmfc_cnt_q is a free-running counter 0..BPM-1 that wraps to 0. It is cleared by reset and never stalls.
- States: ST_CGS, ST_ILAS, ST_DATA. Reset state is ST_CGS.
- mf_cnt_q counts 0..ILAS_MULTIFRAMES-1 inside ILAS. It increments on each lmfc wrap and is cleared on entering ILAS.
- low_cnt_q counts consecutive beats with sync_ni low. It is cleared when sync_ni is high and held at 0 in ST_CGS.
- ST_CGS -> ST_ILAS: when sync_ni==1 and lmfc_cnt_q==BPM-1 in the same cycle. ILAS therefore starts with lmfc_cnt_q==0.
- ST_ILAS -> ST_DATA: on the beat where mf_cnt_q==ILAS_MULTIFRAMES-1 and lmfc_cnt_q==BPM-1.
- ST_ILAS or ST_DATA -> ST_CGS: when sync_ni==0 and low_cnt_q==RESYNC_BEATS-1, i.e. the RESYNC_BEATS-th consecutive low beat.
  - This transition has priority over ILAS -> DATA in the same cycle.
- tx_ready_o is combinational and equals (state_q==ST_DATA), including the beat on which resync fires; that beat's data is still transmitted.
- Output latency: tx_octets_o, tx_charisk_o, lmfc_o and link_up_o are registered. Their value in cycle n+1 is a function of state_q, lmfc_cnt_q, mf_cnt_q, tx_data_i and ilas_cfg_i in cycle n.
- Octet contents in ST_CGS: all octets 0xBC (K28.5), charisk all ones.
- Octet contents in ST_DATA: tx_data_i passed through unchanged, charisk all zeros. There is no character replacement and no scrambling.
- Octet contents in ST_ILAS: octet index i = lmfc_cnt_q*P + lane, with m = mf_cnt_q. Rules, in priority order:
  - i==0: 0x1C (/R/, K28.0), k=1.
  - i==MF-1: 0x7C (/A/, K28.3), k=1.
  - m==1 and i==1: 0x9C (/Q/, K28.4), k=1.
  - m==1 and 2<=i<=15: ilas_cfg_i octet i-2, k=0.
  - otherwise: i[7:0] (ramp), k=0.
- lmfc_o register loads (lmfc_cnt_q==0) in all states.
- link_up_o register loads (state_q==ST_DATA).
- Reset values: tx_octets_o = all 0xBC; tx_charisk_o = all ones; lmfc_o=0; link_up_o=0; tx_ready_o=0; all counters 0.
- Reset mid-operation: at the next edge the state returns to ST_CGS, lmfc_cnt_q restarts at 0, and the outputs take their reset values. A partial ILAS is abandoned and is not resumed.
- A sync_ni glitch high in ST_CGS has effect only if it coincides with lmfc_cnt_q==BPM-1.
- A low pulse shorter than RESYNC_BEATS in ILAS/DATA has no effect; low_cnt_q clears when sync_ni returns high.

Test Plan (P=4, F=2, K=16, so MF=32 and BPM=8; octets listed lane 3..0):
- Reset, sync_ni=0 for 20 cycles -> every beat is BC BC BC BC, charisk 1111, tx_ready_o=0, link_up_o=0; lmfc_o pulses every 8 cycles.
- sync_ni rises while lmfc_cnt_q==3 -> CGS continues to the wrap. First ILAS beat is 03 02 01 1C, charisk 0001, lmfc_o=1. Beat 7 of mf0 is 7C 1E 1D 1C, charisk 1000.
- ILAS mf1 with ilas_cfg_i octets = 0x00..0x0D -> beat 0 is 01 00 9C 1C, charisk 0011; beat 1 is 05 04 03 02; beat 3 is 0D 0C 0B 0A, charisk 0000; beat 4 is ramp 13 12 11 10.
- After 32 ILAS beats -> tx_ready_o=1. tx_data_i=0xDEADBEEF appears one cycle later on tx_octets_o with charisk 0000 and link_up_o=1.
- In DATA, sync_ni low for 3 beats then high -> stays in DATA. sync_ni low for 4 beats -> link_up_o falls and BC BC BC BC appears on the 5th edge.
- Assert rst_i during ILAS mf2 -> next cycle outputs are BC x4, charisk 1111, lmfc_o=0. ILAS restarts from mf0 on a later LMFC wrap.
